// File: rtl/obi_pkg.sv
// OBI bus request/response structures shared by initiators and responders.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/trng_key_fetch_pkg.sv
// Shared state encodings and default TRNG register map for the key fetcher.
package trng_key_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_ACK_SET,
    ST_ACK_CLR,
    ST_KEY_HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_REQ,
    PH_WAIT
  } obi_phase_e;

  localparam logic [31:0] TRNG_DATA_ADDR     = 32'h3008_0000;
  localparam logic [31:0] TRNG_CTRL_ADDR     = 32'h3009_0000;
  localparam logic [31:0] TRNG_ACK_SET_WDATA = 32'h0000_0005;
  localparam logic [31:0] TRNG_ACK_CLR_WDATA = 32'h0000_0004;
  localparam logic [3:0]  OBI_BE_WORD        = 4'hF;

endpackage

// File: rtl/trng_obi_single_master.sv
// Single-outstanding OBI initiator: a start pulse launches one REQ/WAIT transaction.
module trng_obi_single_master
  import obi_pkg::*;
  import trng_key_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output obi_req_t    obi_req,
  input  obi_resp_t   obi_resp
);

  obi_phase_e  phase_reg, phase_next;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        accept;

  // A new command may be accepted in the same cycle the previous one completes,
  // so back-to-back transactions need no idle cycle in between.
  always_comb begin
    phase_next = phase_reg;
    done       = 1'b0;
    accept     = 1'b0;
    unique case (phase_reg)
      PH_IDLE: accept = start;
      PH_REQ: begin
        if (obi_resp.gnt) phase_next = PH_WAIT;
      end
      PH_WAIT: begin
        if (obi_resp.rvalid) begin
          done       = 1'b1;
          accept     = start;
          phase_next = PH_IDLE;
        end
      end
      default: phase_next = PH_IDLE;
    endcase
    if (accept) phase_next = PH_REQ;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      phase_reg <= PH_IDLE;
      we_reg    <= 1'b0;
      be_reg    <= 4'h0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      phase_reg <= phase_next;
      if (accept) begin
        we_reg    <= we;
        be_reg    <= OBI_BE_WORD;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
    end
  end

  // Command fields come straight from registers, so they cannot move while req is high.
  assign obi_req.req   = (phase_reg == PH_REQ);
  assign obi_req.we    = we_reg;
  assign obi_req.be    = be_reg;
  assign obi_req.addr  = addr_reg;
  assign obi_req.wdata = wdata_reg;
  assign rdata         = obi_resp.rdata;

endmodule

// File: rtl/trng_key_fetch.sv
// Assembles an N_WORDS x 32-bit key from a TRNG over OBI: per interrupt, read one
// data word, then pulse the ack bit in the control register.
module trng_key_fetch
  import obi_pkg::*;
  import trng_key_fetch_pkg::*;
#(
  parameter int unsigned N_WORDS       = 4,
  parameter logic [31:0] DATA_ADDR     = TRNG_DATA_ADDR,
  parameter logic [31:0] CTRL_ADDR     = TRNG_CTRL_ADDR,
  parameter logic [31:0] ACK_SET_WDATA = TRNG_ACK_SET_WDATA,
  parameter logic [31:0] ACK_CLR_WDATA = TRNG_ACK_CLR_WDATA
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   trng_intr_i,
  output obi_req_t               obi_req_o,
  input  obi_resp_t              obi_resp_i,
  output logic [32*N_WORDS-1:0]  key_o,
  output logic                   key_valid_o,
  input  logic                   key_ready_i,
  output logic                   busy_o
);

  localparam int unsigned      CNT_W    = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);

  fetch_state_e     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_reg, pend_next;
  logic             intr_reg;
  logic             intr_edge;
  logic             word_capture;
  logic             key_clear;

  logic             mst_start;
  logic             mst_we;
  logic [31:0]      mst_addr;
  logic [31:0]      mst_wdata;
  logic             mst_done;
  logic [31:0]      mst_rdata;

  assign intr_edge = trng_intr_i & ~intr_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pend_next    = pend_reg | intr_edge;
    mst_start    = 1'b0;
    word_capture = 1'b0;
    key_clear    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (enable_i && (pend_reg || intr_edge)) begin
          state_next = ST_RD;
          pend_next  = 1'b0;
          mst_start  = 1'b1;
        end
      end
      ST_RD, ST_ACK_SET, ST_ACK_CLR: begin
        if (mst_done) begin
          word_capture = (state_reg == ST_RD);
          if (!enable_i) begin
            // Disabled mid-sequence: let the finished transaction stand, drop the rest.
            state_next = ST_IDLE;
            cnt_next   = '0;
            pend_next  = 1'b0;
            key_clear  = 1'b1;
          end else if (state_reg == ST_RD) begin
            state_next = ST_ACK_SET;
            mst_start  = 1'b1;
          end else if (state_reg == ST_ACK_SET) begin
            state_next = ST_ACK_CLR;
            mst_start  = 1'b1;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = ST_KEY_HOLD;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end
      ST_KEY_HOLD: begin
        if (key_ready_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The command handed to the initiator follows the state being entered.
  always_comb begin
    mst_we    = 1'b0;
    mst_addr  = DATA_ADDR;
    mst_wdata = '0;
    if (state_next == ST_ACK_SET) begin
      mst_we    = 1'b1;
      mst_addr  = CTRL_ADDR;
      mst_wdata = ACK_SET_WDATA;
    end else if (state_next == ST_ACK_CLR) begin
      mst_we    = 1'b1;
      mst_addr  = CTRL_ADDR;
      mst_wdata = ACK_CLR_WDATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
      intr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      intr_reg  <= trng_intr_i;
    end
  end

  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_key_word
    logic [31:0] word_reg;

    always_ff @(posedge clk_i) begin
      if (rst_i || key_clear) begin
        word_reg <= '0;
      end else if (word_capture && (cnt_reg == CNT_W'(gi))) begin
        word_reg <= mst_rdata;
      end
    end

    assign key_o[32*gi +: 32] = word_reg;
  end

  trng_obi_single_master u_obi_master (
    .clk      (clk_i),
    .srst     (rst_i),
    .start    (mst_start),
    .we       (mst_we),
    .addr     (mst_addr),
    .wdata    (mst_wdata),
    .done     (mst_done),
    .rdata    (mst_rdata),
    .obi_req  (obi_req_o),
    .obi_resp (obi_resp_i)
  );

  assign key_valid_o = (state_reg == ST_KEY_HOLD);
  assign busy_o      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_trng_key_fetch.sv
// Scoreboard bench for trng_key_fetch: a behavioural OBI responder checks every
// transaction against an expected queue; assembled keys are checked against a key queue.
module tb_trng_key_fetch;
  import obi_pkg::*;

  localparam int          N      = 4;
  localparam logic [31:0] DATA_A = 32'h3008_0000;
  localparam logic [31:0] CTRL_A = 32'h3009_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            intr;
  logic            key_ready;
  obi_req_t        obi_req;
  obi_resp_t       obi_resp;
  logic [32*N-1:0] key;
  logic            key_valid;
  logic            busy;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          txn_no = 0;
  int          gnt_dly = 0;
  int          rv_dly  = 1;
  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [127:0] key_q[$];

  always #5 clk = ~clk;

  trng_key_fetch #(.N_WORDS(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .trng_intr_i (intr),
    .obi_req_o   (obi_req),
    .obi_resp_i  (obi_resp),
    .key_o       (key),
    .key_valid_o (key_valid),
    .key_ready_i (key_ready),
    .busy_o      (busy)
  );

  task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: grants after gnt_dly cycles, answers rvalid_dly cycles after the grant.
  initial begin : responder
    obi_req_t    cap;
    txn_t        e;
    logic [31:0] rdv;
    obi_resp = '0;
    forever begin
      @(negedge clk);
      obi_resp.rvalid = 1'b0;
      if (!rst && obi_req.req === 1'b1) begin
        cap = obi_req;
        chk_val("txn_be", 128'(cap.be), 128'(4'hF));
        for (int i = 0; i < gnt_dly; i++) begin
          @(negedge clk);
          chk_val("req_stable", 128'(obi_req), 128'(cap));
        end
        obi_resp.gnt = 1'b1;
        @(negedge clk);
        obi_resp.gnt = 1'b0;
        chk_val("wait_no_req", 128'(obi_req.req), 128'(0));
        for (int i = 1; i < rv_dly; i++) begin
          @(negedge clk);
          chk_val("wait_no_req", 128'(obi_req.req), 128'(0));
        end
        if (exp_q.size() == 0) begin
          chk_val("unexpected_txn", 128'(cap.addr), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk_val("txn_we", 128'(cap.we), 128'(e.we));
          chk_val("txn_addr", 128'(cap.addr), 128'(e.addr));
          if (e.we) chk_val("txn_wdata", 128'(cap.wdata), 128'(e.wdata));
        end
        rdv = 32'hDEAD_BEEF;
        if (!cap.we && rd_q.size() > 0) rdv = rd_q.pop_front();
        obi_resp.rdata  = cap.we ? 32'h0 : rdv;
        obi_resp.rvalid = 1'b1;
        txn_no++;
        $display("txn %0d: we=%0b addr=%h data=%h", txn_no, cap.we, cap.addr,
                 cap.we ? cap.wdata : rdv);
      end
    end
  end

  task automatic push_word(input logic [31:0] d);
    rd_q.push_back(d);
    exp_q.push_back('{1'b0, DATA_A, 32'h0});
    exp_q.push_back('{1'b1, CTRL_A, 32'h5});
    exp_q.push_back('{1'b1, CTRL_A, 32'h4});
  endtask

  task automatic pulse_intr();
    intr = 1'b1;
    repeat (2) @(negedge clk);
    intr = 1'b0;
  endtask

  task automatic wait_settle(input string tag);
    int c = 0;
    while (busy && !key_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (busy && !key_valid) chk_val({tag, "_timeout"}, 128'(c), 128'(0));
  endtask

  task automatic check_key(input string tag);
    int c = 0;
    int hold_bad = 0;
    logic [127:0] e;
    while (!key_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk_val({tag, "_valid"}, 128'(key_valid), 128'(1));
    e = key_q.pop_front();
    chk_val({tag, "_key"}, 128'(key), e);
    key_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (key !== e || obi_req.req !== 1'b0 || key_valid !== 1'b1) hold_bad++;
    end
    chk_val({tag, "_hold"}, 128'(hold_bad), 128'(0));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    chk_val({tag, "_released"}, 128'({key_valid, busy}), 128'(0));
  endtask

  task automatic fetch_key(input logic [31:0] w0, w1, w2, w3, input string tag);
    key_q.push_back({w3, w2, w1, w0});
    push_word(w0);
    push_word(w1);
    push_word(w2);
    push_word(w3);
    repeat (N) begin
      pulse_intr();
      wait_settle(tag);
    end
    check_key(tag);
    chk_val({tag, "_txns_left"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int idle_bad;
    int c;
    rst       = 1'b1;
    enable    = 1'b0;
    intr      = 1'b0;
    key_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_obi_req", 128'(obi_req), 128'(0));
    chk_val("rst_key", 128'(key), 128'(0));
    chk_val("rst_key_valid", 128'(key_valid), 128'(0));
    chk_val("rst_busy", 128'(busy), 128'(0));
    rst    = 1'b0;
    enable = 1'b1;

    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (obi_req.req !== 1'b0 || key_valid !== 1'b0 || busy !== 1'b0) idle_bad++;
    end
    chk_val("idle_100_cycles", 128'(idle_bad), 128'(0));

    // Zero-wait responder, four interrupts, one full key.
    gnt_dly = 0;
    rv_dly  = 1;
    fetch_key(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, "A");

    // Slow responder: grant after 3 cycles, rvalid 2 cycles after the grant.
    gnt_dly = 3;
    rv_dly  = 2;
    fetch_key(32'hA5A5_0001, 32'h5A5A_0002, 32'hFFFF_0003, 32'h0000_8004, "B");

    // Interrupt edge during word 0 ack-set: word 1 follows without a new edge.
    gnt_dly = 0;
    rv_dly  = 1;
    key_q.push_back({32'hC4C4_C4C4, 32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1});
    push_word(32'hC1C1_C1C1);
    push_word(32'hC2C2_C2C2);
    push_word(32'hC3C3_C3C3);
    push_word(32'hC4C4_C4C4);
    pulse_intr();
    c = 0;
    while (!(obi_req.req === 1'b1 && obi_req.we === 1'b1 && obi_req.wdata === 32'h5) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk_val("C_ack_set_seen", 128'(obi_req.wdata), 128'(32'h5));
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
    wait_settle("C_w0");
    @(negedge clk);
    chk_val("C_no_idle_wait", 128'(busy), 128'(1));
    chk_val("C_word1_rd_req", 128'({obi_req.req, obi_req.we}), 128'(2'b10));
    wait_settle("C_w1");
    repeat (2) begin
      pulse_intr();
      wait_settle("C");
    end
    check_key("C");
    chk_val("C_txns_left", 128'(exp_q.size()), 128'(0));

    // Enable dropped during the read wait of word 2: read completes, no acks.
    rv_dly = 2;
    push_word(32'hD1D1_0000);
    push_word(32'hD2D2_0000);
    repeat (2) begin
      pulse_intr();
      wait_settle("D");
    end
    rd_q.push_back(32'hD3D3_0000);
    exp_q.push_back('{1'b0, DATA_A, 32'h0});
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
    chk_val("D_rd_req", 128'({obi_req.req, obi_req.we}), 128'(2'b10));
    @(negedge clk);
    enable = 1'b0;
    wait_settle("D_abort");
    chk_val("D_idle", 128'(busy), 128'(0));
    chk_val("D_key_discard", 128'(key), 128'(0));
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (obi_req.req !== 1'b0 || busy !== 1'b0) idle_bad++;
    end
    chk_val("D_no_acks", 128'(idle_bad), 128'(0));
    chk_val("D_txns_left", 128'(exp_q.size()), 128'(0));
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk_val("D_pend_cleared", 128'(busy), 128'(0));
    rv_dly = 1;
    fetch_key(32'hE1E1_E1E1, 32'hE2E2_E2E2, 32'hE3E3_E3E3, 32'hE4E4_E4E4, "D_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
